// File: rtl/rgb_pwm_driver_pkg.sv
// Shared widths, channel offsets and the duty-triplet type for the RGB PWM driver.
package rgb_pwm_driver_pkg;

   localparam int RGB_W = 24;
   localparam int CH_W  = 8;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } duty_t;

   function automatic duty_t unpack_rgb(input logic [RGB_W-1:0] rgb);
      duty_t d;
      d.r = rgb[R_LSB +: CH_W];
      d.g = rgb[G_LSB +: CH_W];
      d.b = rgb[B_LSB +: CH_W];
      return d;
   endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Converter-side bus: read request shared with the converter and its 24-bit rgb result.
interface rgb_pwm_driver_if;
   import rgb_pwm_driver_pkg::*;

   logic             enable;
   logic [RGB_W-1:0] rgb;

   modport master (output enable, output rgb);
   modport slave  (input  enable, input  rgb);

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: duty register loaded on strobe, registered compare against the shared counter.
module pwm_channel
   import rgb_pwm_driver_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [CH_W-1:0] duty_in,
   input  logic [CH_W-1:0] cnt,
   output logic            pwm
);

   logic [CH_W-1:0] duty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty <= '0;
         pwm  <= 1'b0;
      end else begin
         if (load) duty <= duty_in;
         pwm <= (cnt < duty);
      end
   end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Tri-colour PWM driver fed by the colour converter; new colours take effect only at period boundaries.
module rgb_pwm_driver
   import rgb_pwm_driver_pkg::*;
#(
   parameter int PRESCALE     = 1,
   parameter int READ_LATENCY = 1
)(
   input  logic            clk,
   input  logic            rst_n,
   rgb_pwm_driver_if.slave bus,
   output logic            pwm_r,
   output logic            pwm_g,
   output logic            pwm_b,
   output logic            frame_start,
   output logic            pending
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [READ_LATENCY-1:0] vld_p;
   logic                    rgb_valid;
   logic [PS_W-1:0]         pre_cnt;
   logic                    tick;
   logic [CH_W-1:0]         pwm_cnt;
   logic                    boundary;
   duty_t                   shadow;
   duty_t                   load_duty;
   logic                    load;

   assign rgb_valid = vld_p[READ_LATENCY-1];
   assign tick      = (pre_cnt == PS_MAX);
   assign boundary  = tick && (pwm_cnt == {CH_W{1'b1}});

   // A colour arriving in the boundary cycle itself bypasses the shadow.
   assign load      = boundary && (pending || rgb_valid);
   assign load_duty = rgb_valid ? unpack_rgb(bus.rgb) : shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p       <= '0;
         pre_cnt     <= '0;
         pwm_cnt     <= '0;
         frame_start <= 1'b0;
         pending     <= 1'b0;
         shadow      <= '0;
      end else begin
         vld_p[0] <= bus.enable;
         for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];

         pre_cnt <= tick ? '0 : pre_cnt + PS_W'(1);
         if (tick) pwm_cnt <= pwm_cnt + 8'd1;
         frame_start <= boundary;

         if (boundary) begin
            pending <= 1'b0;
         end else if (rgb_valid) begin
            shadow  <= unpack_rgb(bus.rgb);
            pending <= 1'b1;
         end
      end
   end

   pwm_channel u_ch_r (.clk(clk), .rst_n(rst_n), .load(load), .duty_in(load_duty.r), .cnt(pwm_cnt), .pwm(pwm_r));
   pwm_channel u_ch_g (.clk(clk), .rst_n(rst_n), .load(load), .duty_in(load_duty.g), .cnt(pwm_cnt), .pwm(pwm_g));
   pwm_channel u_ch_b (.clk(clk), .rst_n(rst_n), .load(load), .duty_in(load_duty.b), .cnt(pwm_cnt), .pwm(pwm_b));

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_rgb_pwm_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   rgb_pwm_driver_if bus1 ();
   rgb_pwm_driver_if bus4 ();

   logic pr1, pg1, pb1, fs1, pd1;
   logic pr4, pg4, pb4, fs4, pd4;

   rgb_pwm_driver #(.PRESCALE(1), .READ_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .pwm_r(pr1), .pwm_g(pg1), .pwm_b(pb1), .frame_start(fs1), .pending(pd1));

   rgb_pwm_driver #(.PRESCALE(4), .READ_LATENCY(1)) u4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4),
      .pwm_r(pr4), .pwm_g(pg4), .pwm_b(pb4), .frame_start(fs4), .pending(pd4));

   int checks   = 0;
   int failures = 0;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input bit s4, input int maxc, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         step(1);
         seen = s4 ? fs4 : fs1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic measure(input bit s4, input int n,
                          output int hr, output int hg, output int hb,
                          output int fs, output int runr, output int pdany);
      int run;
      hr = 0; hg = 0; hb = 0; fs = 0; runr = 0; pdany = 0; run = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (s4 ? pr4 : pr1) begin
            hr++; run++;
            if (run > runr) runr = run;
         end else begin
            run = 0;
         end
         if (s4 ? pg4 : pg1) hg++;
         if (s4 ? pb4 : pb1) hb++;
         if (s4 ? fs4 : fs1) fs++;
         if (s4 ? pd4 : pd1) pdany++;
      end
   endtask

   task automatic load(input bit s4, input logic [23:0] c);
      if (s4) begin
         bus4.enable = 1'b1; step(1);
         bus4.enable = 1'b0; bus4.rgb = c; step(1);
         bus4.rgb = '0;
      end else begin
         bus1.enable = 1'b1; step(1);
         bus1.enable = 1'b0; bus1.rgb = c; step(1);
         bus1.rgb = '0;
      end
   endtask

   int hr, hg, hb, fs, runr, pdany;

   initial begin
      rst_n = 1'b0;
      bus1.enable = 1'b0; bus1.rgb = '0;
      bus4.enable = 1'b0; bus4.rgb = '0;
      #12;
      chk("rst_pwm", {29'd0, pr1, pg1, pb1}, 32'd0);
      chk("rst_fs_pd", {30'd0, fs1, pd1}, 32'd0);
      step(2);
      rst_n = 1'b1;

      // First period after reset: all low, frame_start once at the end.
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("init_r", hr, 0); chk("init_g", hg, 0); chk("init_b", hb, 0);
      chk("init_fs", fs, 1); chk("init_fs_last", fs1, 1); chk("init_pd", pdany, 0);

      // Basic load 0xFF8000.
      load(0, 24'hFF8000);
      chk("basic_pending", pd1, 1);
      wait_frame(0, 300, "basic_frame");
      chk("basic_pending_clr", pd1, 0);
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("basic_r", hr, 255); chk("basic_g", hg, 128); chk("basic_b", hb, 0);
      chk("basic_fs", fs, 1);

      // Last-wins: 0x101010 then 0x202020.
      bus1.enable = 1'b1; step(1);
      bus1.rgb = 24'h101010; step(1);
      bus1.enable = 1'b0; bus1.rgb = 24'h202020; step(1);
      bus1.rgb = '0;
      chk("lw_pending", pd1, 1);
      wait_frame(0, 300, "lw_frame");
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("lw_r", hr, 32); chk("lw_g", hg, 32); chk("lw_b", hb, 32);
      chk("lw_run_r", runr, 32);

      // Boundary coincidence: valid data lands in the pwm_cnt=255 cycle.
      step(254);
      chk("coin_pd_pre", pd1, 0);
      bus1.enable = 1'b1; step(1);
      bus1.enable = 1'b0; bus1.rgb = 24'h400000;
      chk("coin_pd_valid", pd1, 0);
      step(1);
      bus1.rgb = '0;
      chk("coin_fs", fs1, 1);
      chk("coin_pd_post", pd1, 0);
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("coin_r", hr, 64); chk("coin_g", hg, 0); chk("coin_b", hb, 0);
      chk("coin_pd_never", pdany, 0);

      // Extremes: 0x00FF00.
      load(0, 24'h00FF00);
      wait_frame(0, 300, "ext_frame");
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("ext_r", hr, 0); chk("ext_g", hg, 255); chk("ext_b", hb, 0);
      chk("ext_g_low_at_255", pg1, 0);

      // Asynchronous reset mid-period with 0x80 active and a colour pending.
      load(0, 24'h808080);
      wait_frame(0, 300, "mid_frame");
      step(10);
      chk("mid_r_high", pr1, 1);
      load(0, 24'h123456);
      chk("mid_pending", pd1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pwm", {29'd0, pr1, pg1, pb1}, 32'd0);
      chk("async_pd", pd1, 0);
      chk("async_fs", fs1, 0);
      #2 rst_n = 1'b1;
      measure(0, 256, hr, hg, hb, fs, runr, pdany);
      chk("post_rst_rgb", hr + hg + hb, 0);
      chk("post_rst_fs", fs, 1);
      chk("post_rst_pd", pdany, 0);

      // PRESCALE=4 with 0x800000.
      load(1, 24'h800000);
      chk("ps4_pending", pd4, 1);
      wait_frame(1, 1100, "ps4_frame");
      chk("ps4_pending_clr", pd4, 0);
      measure(1, 1024, hr, hg, hb, fs, runr, pdany);
      chk("ps4_r", hr, 512); chk("ps4_run_r", runr, 512);
      chk("ps4_gb", hg + hb, 0); chk("ps4_fs", fs, 1); chk("ps4_fs_last", fs4, 1);
      measure(1, 1024, hr, hg, hb, fs, runr, pdany);
      chk("ps4_r2", hr, 512); chk("ps4_fs2", fs, 1); chk("ps4_fs2_last", fs4, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
